// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - multiplexed seven-segment scanner with frame-synchronous
// double-buffered digit data, leading-zero blanking and per-slot PWM dimming.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 1000,
  parameter int PWM_BITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    freeze,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int NW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(REFRESH_DIV - 1);

  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [NW-1:0]         pend_data_q, pend_data_d;
  logic [NW-1:0]         act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic                  pending_q, pending_d;
  logic                  blank_lz_q, blank_lz_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  tick;
  logic                  slot_start;
  logic                  frame_end;
  logic                  blank_en;
  logic [PWM_BITS-1:0]   bright_eff;
  logic [3:0]            nibble;
  logic                  dot;
  logic                  upper_zero;
  logic                  digit_blank;
  logic                  lit;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    tick       = (div_cnt_q == LAST_DIV);
    slot_start = (div_cnt_q == '0);
    frame_end  = tick && (idx_q == LAST_IDX) && !freeze;

    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    pwm_cnt_d = tick ? '0 : pwm_cnt_q + PWM_BITS'(1);
    idx_d     = idx_q;
    if (tick && !freeze) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
    end

    // Slot-start inputs take effect in the first slot cycle and are held for the rest.
    blank_en   = slot_start ? blank_lz   : blank_lz_q;
    bright_eff = slot_start ? brightness : bright_q;
    blank_lz_d = blank_en;
    bright_d   = bright_eff;

    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pending_d   = pending_q;
    if (frame_end && wr_en) begin
      act_data_d = wr_data;
      act_dp_d   = dp_in;
      pending_d  = 1'b0;
    end else begin
      if (frame_end && pending_q) begin
        act_data_d = pend_data_q;
        act_dp_d   = pend_dp_q;
        pending_d  = 1'b0;
      end
      if (wr_en) begin
        pend_data_d = wr_data;
        pend_dp_d   = dp_in;
        pending_d   = 1'b1;
      end
    end

    // A digit is a leading zero only if it and every more-significant digit are blank-worthy.
    nibble     = 4'h0;
    dot        = 1'b0;
    upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (int'(idx_q) == k) begin
        nibble = act_data_q[4*k +: 4];
        dot    = act_dp_q[k];
      end
      if ((k >= int'(idx_q)) && ((act_data_q[4*k +: 4] != 4'h0) || act_dp_q[k])) begin
        upper_zero = 1'b0;
      end
    end
    digit_blank = blank_en && (idx_q != '0) && upper_zero;
    lit = !digit_blank && ((bright_eff == '1) || (pwm_cnt_q < bright_eff));

    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = !(lit && (int'(idx_q) == k));
    end
    seg_d = digit_blank ? 7'h7F : hex_seg(nibble);
    dp_d  = digit_blank ? 1'b1 : !dot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      pwm_cnt_q   <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pending_q   <= 1'b0;
      blank_lz_q  <= 1'b0;
      bright_q    <= '0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      pending_q   <= pending_d;
      blank_lz_q  <= blank_lz_d;
      bright_q    <= bright_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_done = frame_end;

endmodule
